uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receiver. It generates the 16x oversample tick (`i_clk_rx` of the receiver) from a programmable divisor, qualifies the line (idle-arming, false-start rejection) and times each 10-bit frame in parallel with the receiver. It checks the stop bit, captures the receiver's `o_rx_data` at end of frame into a small FIFO, and hands bytes to the host with valid/ready. It also reports framing and overrun errors.

Parameters:
DIV_W, 16, width of baud divisor
DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_enable  in  1  controller enable; 0 = halt ticks, FSM to IDLE
i_divisor  in  DIV_W  clk cycles per oversample tick, minus 1
i_rxd  in  1  synchronized serial line (same signal the receiver sees)
i_rx_data  in  8  receiver parallel output
o_clk_rx  out  1  one-cycle oversample tick to receiver
o_busy  out  1  frame in progress
o_data  out  8  FIFO head byte
o_valid  out  1  FIFO non-empty
i_ready  in  1  host accepts o_data
o_frame_err  out  1  sticky: stop bit sampled 0
o_overrun  out  1  sticky: good byte dropped, FIFO full
i_clear  in  1  clears sticky flags

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, all counters 0.
- Tick generator:
  - `div_cnt` held 0 while i_enable=0.
  - Otherwise it counts up. When `div_cnt >= i_divisor`, o_clk_rx=1 for that cycle and `div_cnt` wraps to 0.
  - i_divisor=0 gives a tick every clk. A divisor change takes effect immediately via the >= compare.
- `tick_cnt` (8 bit) counts ticks within a frame, 0..159 (10 bits x 16).
- FSM states: IDLE, ARM, FRAME, CAPTURE.
  - IDLE: count consecutive ticks with i_rxd=1; any tick with i_rxd=0 resets the count. 16 consecutive high ticks -> ARM.
  - ARM: first clk with i_rxd=0 -> FRAME, with `tick_cnt`=0 and `div_cnt`=0 (re-phase). o_busy=1 from this transition.
  - FRAME, on each tick `tick_cnt`++:
    - At tick 8 (mid start bit) with i_rxd=1: false start -> ARM, no error.
    - At tick 152 (mid stop bit): latch stop = i_rxd.
    - At tick 159: -> CAPTURE.
  - CAPTURE (1 clk, o_busy=1):
    - stop=1: push i_rx_data. If FIFO full and no pop this cycle, drop the byte, set o_overrun, -> ARM.
    - stop=0: byte discarded, set o_frame_err, -> IDLE (re-arm; covers break).
- o_busy=1 in FRAME and CAPTURE only.
- i_enable dropping mid-frame: FSM -> IDLE next clk, `tick_cnt`=0, no push, no flags. FIFO contents and flags are retained.
- FIFO:
  - o_data shows the head combinationally (first-word-fall-through). o_valid = count != 0.
  - Pop when o_valid && i_ready. Pointers wrap mod DEPTH; count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle when full: both succeed, no overrun, count unchanged.
  - Pop when empty is ignored.
- Sticky flags:
  - i_clear=1 zeroes o_frame_err and o_overrun.
  - A set event in the same cycle as i_clear wins (flag reads 1).
- Push latency: byte is visible on o_data/o_valid the clk after CAPTURE.

Optional Feature:
UART_RX_CTRL_ERR_CNT_EN
- Defined: adds output port o_err_cnt [7:0]. It increments by 1 on each frame-error or overrun event, saturates at 255, and clears to 0 on i_clear (a same-cycle event gives 1). Reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- i_divisor=3, line idle 64 ticks, then frame 0xA5 with stop=1; receiver model drives i_rx_data=0xA5 by tick 159 -> o_clk_rx every 4 clks; o_busy high about 640 clks; o_valid=1, o_data=0xA5 one clk after CAPTURE; flags 0.
- Armed, 2-tick low glitch on i_rxd -> false start at tick 8, FSM back to ARM; no push, no flags, o_busy drops.
- Frame 0x3C with stop bit 0 -> o_frame_err=1, FIFO unchanged, FSM in IDLE; next frame accepted only after 16 high ticks; i_clear -> flag 0.
- i_ready=0, 5 good frames 0x01..0x05 with DEPTH=4 -> FIFO holds 0x01..0x04, o_overrun=1; then pop 4 with i_ready=1 -> bytes in order, o_valid=0.
- FIFO full, host pops in the same cycle as CAPTURE of 0x77 -> no overrun, 0x77 lands last, count stays 4.
- i_enable deasserted at tick 80 of frame, re-enabled -> no push; must see 16 idle ticks before the next frame (0x5A) is received correctly. With UART_RX_CTRL_ERR_CNT_EN defined, 2 frame errors then 1 overrun -> o_err_cnt=3.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: oversample tick, line qualification, frame timing, FWFT byte FIFO
// Define UART_RX_CTRL_ERR_CNT_EN to add the saturating o_err_cnt error counter.
module uart_rx_ctrl #(
  parameter int DIV_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_rxd,
  input  logic [7:0]       i_rx_data,
  output logic             o_clk_rx,
  output logic             o_busy,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_frame_err,
  output logic             o_overrun,
  input  logic             i_clear
`ifdef UART_RX_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]       o_err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, FRAME, CAPTURE} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [7:0]       tick_cnt_q;
  logic [3:0]       idle_cnt_q;
  logic             stop_q;
  logic             busy_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  logic tick;
  logic start;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic fe_set;
  logic ov_set;

  assign tick    = i_enable && (div_cnt_q >= i_divisor);
  assign start   = i_enable && (state_q == ARM) && !i_rxd;
  assign capture = i_enable && (state_q == CAPTURE);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = o_valid && i_ready;
  // A full FIFO still accepts the byte when the host frees a slot in the same cycle.
  assign push    = capture && stop_q && (!full || pop);
  assign fe_set  = capture && !stop_q;
  assign ov_set  = capture && stop_q && full && !pop;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  assign o_clk_rx    = tick;
  assign o_busy      = busy_q;
  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

  // The start edge re-phases the divider so ticks line up with bit centres.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else if (!i_enable || start || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= 8'd0;
      idle_cnt_q <= 4'd0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!i_enable) begin
      state_q    <= IDLE;
      tick_cnt_q <= 8'd0;
      idle_cnt_q <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            if (!i_rxd) begin
              idle_cnt_q <= 4'd0;
            end else if (idle_cnt_q == 4'd15) begin
              idle_cnt_q <= 4'd0;
              state_q    <= ARM;
            end else begin
              idle_cnt_q <= idle_cnt_q + 4'd1;
            end
          end
        end
        ARM: begin
          if (!i_rxd) begin
            state_q    <= FRAME;
            tick_cnt_q <= 8'd0;
            busy_q     <= 1'b1;
          end
        end
        FRAME: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
            if ((tick_cnt_q == 8'd8) && i_rxd) begin
              state_q    <= ARM;
              tick_cnt_q <= 8'd0;
              busy_q     <= 1'b0;
            end else if (tick_cnt_q == 8'd152) begin
              stop_q <= i_rxd;
            end else if (tick_cnt_q == 8'd159) begin
              state_q    <= CAPTURE;
              tick_cnt_q <= 8'd0;
            end
          end
        end
        CAPTURE: begin
          busy_q     <= 1'b0;
          idle_cnt_q <= 4'd0;
          state_q    <= stop_q ? ARM : IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // A set event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= fe_set | (frame_err_q & ~i_clear);
      overrun_q   <= ov_set | (overrun_q & ~i_clear);
    end
  end

`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  assign o_err_cnt = err_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else if (i_clear) begin
      err_cnt_q <= (fe_set || ov_set) ? 8'd1 : 8'd0;
    end else if ((fe_set || ov_set) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl (divisor 3, DEPTH 4)
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_enable = 1'b0;
  logic [15:0] i_divisor = 16'd0;
  logic        i_rxd = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_ready = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_clk_rx;
  logic        o_busy;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_overrun;
`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [7:0]  o_err_cnt;
`endif

  int n_total = 0;
  int n_bad = 0;
  int busy_cnt;
  int tick_seen;

  uart_rx_ctrl #(.DIV_W(16), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(i_enable),
    .i_divisor(i_divisor),
    .i_rxd(i_rxd),
    .i_rx_data(i_rx_data),
    .o_clk_rx(o_clk_rx),
    .o_busy(o_busy),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun(o_overrun),
    .i_clear(i_clear)
`ifdef UART_RX_CTRL_ERR_CNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_ticks(input int n);
    i_rxd = 1'b1;
    repeat (n * 4) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; 64 clks per bit at divisor 3.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    i_rx_data = b;
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      i_rxd = bits[j];
      repeat (64) begin
        @(negedge clk);
        busy_cnt += int'(o_busy);
      end
    end
    i_rxd = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, o_valid, 1);
    check(tag, o_data, exp);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tick", o_clk_rx, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 8'h00);
    check("rst_ferr", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    reset = 1'b1;
    @(negedge clk);
    i_enable = 1'b1;

    tick_seen = 0;
    repeat (4) begin
      @(negedge clk);
      tick_seen += int'(o_clk_rx);
    end
    check("div0_ticks", tick_seen, 4);

    i_divisor = 16'd3;
    tick_seen = 0;
    repeat (40) begin
      @(negedge clk);
      tick_seen += int'(o_clk_rx);
    end
    check("div3_ticks", tick_seen, 10);
    idle_ticks(64);

    // Good frame and push latency
    send_frame(8'hA5, 1'b1);
    check("t1_busy_len", busy_cnt, 640);
    @(negedge clk);
    check("t1_cap_busy", o_busy, 1);
    check("t1_cap_valid", o_valid, 0);
    @(negedge clk);
    check("t1_busy_low", o_busy, 0);
    check("t1_ferr", o_frame_err, 0);
    check("t1_ovr", o_overrun, 0);
    pop_check("t1_pop", 8'hA5);
    check("t1_empty", o_valid, 0);

    // False start from ARM
    i_rxd = 1'b0;
    repeat (8) @(negedge clk);
    check("t2_glitch_busy", o_busy, 1);
    i_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t2_busy_drop", o_busy, 0);
    check("t2_no_push", o_valid, 0);
    check("t2_ferr", o_frame_err, 0);
    check("t2_ovr", o_overrun, 0);
    send_frame(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    pop_check("t2_rearm", 8'h11);

    // Framing error, return to IDLE, clear
    send_frame(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_ferr", o_frame_err, 1);
    check("t3_no_push", o_valid, 0);
    check("t3_ovr", o_overrun, 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
    check("t3_errcnt", o_err_cnt, 1);
`endif
    idle_ticks(4);
    i_rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_idle_no_start", o_busy, 0);
    idle_ticks(20);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("t3_ferr_sticky", o_frame_err, 1);
    pop_check("t3_good", 8'h3C);
    clear_pulse();
    check("t3_ferr_clr", o_frame_err, 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
    check("t3_errcnt_clr", o_err_cnt, 0);
`endif

    // Overrun with host stalled
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1);
      repeat (2) @(negedge clk);
    end
    check("t4_ovr", o_overrun, 1);
    check("t4_valid", o_valid, 1);
    check("t4_head", o_data, 8'h01);
    check("t4_ferr", o_frame_err, 0);
    clear_pulse();
    check("t4_ovr_clr", o_overrun, 0);

    // Pop in the same cycle as CAPTURE into a full FIFO
    send_frame(8'h77, 1'b1);
    @(negedge clk);
    check("t5_cap_busy", o_busy, 1);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("t5_no_ovr", o_overrun, 0);
    pop_check("t5_p0", 8'h02);
    pop_check("t5_p1", 8'h03);
    pop_check("t5_p2", 8'h04);
    pop_check("t5_p3", 8'h77);
    check("t5_empty", o_valid, 0);

    // Enable dropped mid-frame
    i_rxd = 1'b0;
    repeat (324) @(negedge clk);
    check("t6_busy_mid", o_busy, 1);
    i_enable = 1'b0;
    @(negedge clk);
    check("t6_busy_off", o_busy, 0);
    check("t6_tick_off", o_clk_rx, 0);
    repeat (8) @(negedge clk);
    i_enable = 1'b1;
    repeat (8) @(negedge clk);
    idle_ticks(8);
    i_rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_not_armed", o_busy, 0);
    check("t6_no_push", o_valid, 0);
    check("t6_ferr", o_frame_err, 0);
    check("t6_ovr", o_overrun, 0);
    idle_ticks(20);
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    pop_check("t6_rx", 8'h5A);
    check("t6_empty", o_valid, 0);

`ifdef UART_RX_CTRL_ERR_CNT_EN
    clear_pulse();
    send_frame(8'h00, 1'b0);
    idle_ticks(20);
    send_frame(8'h00, 1'b0);
    idle_ticks(20);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h40 + 8'(k), 1'b1);
      repeat (2) @(negedge clk);
    end
    check("t7_errcnt", o_err_cnt, 3);
    check("t7_ferr", o_frame_err, 1);
    check("t7_ovr", o_overrun, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
